exp4_trena: RTL and testbench
=============================

Name: exp4_trena

Overview:
- Ultrasonic tape-measure controller for an HC-SR04-style sensor on a 50 MHz clock.
- On a `mensurar` request it does the following, in order:
  - issues a 10 us trigger pulse;
  - times the echo pulse and converts it to centimetres, rounded to nearest, as 3 BCD digits;
  - transmits the result over a UART as ASCII;
  - asserts `pronto`.
- It is the top level of the measurement datapath plus control FSM.

Parameters:
- TRIGGER_CYCLES, 500: trigger pulse width in clocks (10 us).
- CM_CYCLES, 2941: clocks per centimetre of echo (58.82 us).
- CM_HALF, 1470: intra-centimetre count at which the cm counter increments; gives round-to-nearest.
- BAUD_CYCLES, 434: clocks per UART bit (115200 baud).

Ports:
- `clock`, input, 1: system clock, 50 MHz. This is the design's one clock.
- `reset`, input, 1: reset, asynchronous and active-high.
- `mensurar`, input, 1: measurement request; level may last several cycles, acted on at its rising edge.
- `echo`, input, 1: sensor echo; pulse width is proportional to distance.
- `trigger`, output, 1: sensor trigger pulse.
- `saida_serial`, output, 1: UART TX line; idles high.
- `medida0`, output, 4: BCD units digit of the last measurement.
- `medida1`, output, 4: BCD tens digit.
- `medida2`, output, 4: BCD hundreds digit.
- `pronto`, output, 1: measurement and transmission complete.
- `db_estado`, output, 4: current FSM state code, for debug.

Behaviour:
- Reset:
  - FSM goes to `inicial`.
  - `trigger`=0, `saida_serial`=1, `medida0..2`=0, `pronto`=0, `db_estado`=0.
  - All counters are cleared.
  - Reset mid-operation aborts everything immediately, including a UART frame in progress (line returns high).
- `mensurar` edge detect:
  - Registered rising-edge detector; one start per rising edge.
  - Ignored in every state except `inicial` and `final`.
- FSM states (`db_estado` code):
  - `inicial` (0): idle. On `mensurar` edge go to `preparacao`.
  - `preparacao` (1): one cycle; clear the cycle counter and the BCD cm counter. Go to `envia_trigger`.
  - `envia_trigger` (2): `trigger`=1 for exactly TRIGGER_CYCLES clocks. Then go to `espera_echo`.
  - `espera_echo` (3): wait for `echo`=1. There is no timeout; only reset recovers.
  - `medida` (4): while `echo`=1, the intra-cm counter runs modulo CM_CYCLES. Each time it equals CM_HALF, the BCD cm counter increments. `echo` falling edge goes to `armazena`.
  - `armazena` (5): one cycle; latch the BCD counter into `medida2..0`. Then go to `transmite`.
  - `transmite` (6): one-cycle start pulse to the UART with the current character. Then go to `espera_tx`.
  - `espera_tx` (7): wait for the UART done pulse. Then go to `proximo`.
  - `proximo` (8): if 4 characters have been sent, go to `final`; else advance the character index and go to `transmite`.
  - `final` (15): `pronto`=1, held. On `mensurar` edge go to `preparacao`, with `pronto` dropping the next cycle.
- Distance arithmetic:
  - With N = echo-high clocks, the cm counter ends at floor((N − CM_HALF)/CM_CYCLES) + 1 for N ≥ CM_HALF; otherwise 0.
  - 3-digit BCD with carry between digits.
  - Saturates at 999; no wrap.
- Output stability: `medida0..2` change only in `armazena` and otherwise hold the previous result.
- Character sequence, in order:
  - 0x30+`medida2`
  - 0x30+`medida1`
  - 0x30+`medida0`
  - '#' (0x23)
- UART frame, each bit BAUD_CYCLES clocks:
  - 1 start bit (0);
  - 7 data bits, LSB first;
  - 1 even-parity bit;
  - 2 stop bits (1).
  - 11 bits per character. The done pulse is issued at the end of the second stop bit.
- Transmission length: 4 characters = 44×434 = 19096 clocks ≈ 382 us.
- Echo outside `medida`: an echo rising while the FSM is not in `espera_echo` is ignored.

Test Plan:
- Reset: `reset`=1 for 2 us → `trigger`=0, `saida_serial`=1, `pronto`=0, `db_estado`=0, `medida`=000.
- Trigger: `mensurar` high 5 cycles → `trigger` rises within 2 clocks and stays high for exactly 500 clocks.
- Exact distance: echo 5882 us (294100 clocks) after 400 us → `medida2/1/0`=1/0/0. Serial bytes are 0x31,0x30,0x30,0x23 with correct even parity and 2 stop bits. `pronto`=1 about 382 us after echo falls.
- Truncate: echo 5899 us → 100 cm.
- Exact and round-up: echo 4353 us → 74 cm; echo 4399 us → 75 cm. Serial output is "074#" and "075#" respectively.
- Edge cases:
  - `mensurar` during `medida` → ignored.
  - Reset asserted mid-transmission → line high immediately and `db_estado`=0.
  - Echo > 58.8 ms → result saturates at 999.

Source files
------------

// File: rtl/exp4_trena.sv
// ----------------------------------------------------------------------------
// exp4_trena : ultrasonic tape-measure controller (HC-SR04 style sensor)
//
// A rising edge on mensurar starts one measurement. The controller sends a
// trigger pulse and then times the echo pulse in centimetres, rounded to the
// nearest centimetre, as three BCD digits. It latches the result, sends it
// over a UART as "HTU#", and then raises pronto.
//
// Ports
//   clock        : system clock (50 MHz nominal)
//   reset        : asynchronous, active-high reset
//   mensurar     : measurement request, acted on at its rising edge
//   echo         : sensor echo, high time proportional to distance
//   trigger      : sensor trigger pulse, TRIGGER_CYCLES clocks wide
//   saida_serial : UART TX line (7 data bits, even parity, 2 stop bits),
//                  idles high
//   medida0..2   : BCD units / tens / hundreds of the last measurement
//   pronto       : measurement and transmission complete
//   db_estado    : current FSM state code
// ----------------------------------------------------------------------------
module exp4_trena #(
   parameter int TRIGGER_CYCLES = 500,
   parameter int CM_CYCLES      = 2941,
   parameter int CM_HALF        = 1470,
   parameter int BAUD_CYCLES    = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mensurar,
   input  logic       echo,
   output logic       trigger,
   output logic       saida_serial,
   output logic [3:0] medida0,
   output logic [3:0] medida1,
   output logic [3:0] medida2,
   output logic       pronto,
   output logic [3:0] db_estado
);

   // One shared cycle counter times the trigger pulse and then the intra-cm echo count
   localparam int CNT_MAX = (TRIGGER_CYCLES > CM_CYCLES) ? TRIGGER_CYCLES : CM_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BAUD_W  = $clog2(BAUD_CYCLES + 1);

   typedef enum logic [3:0] {
      ST_INICIAL       = 4'd0,
      ST_PREPARACAO    = 4'd1,
      ST_ENVIA_TRIGGER = 4'd2,
      ST_ESPERA_ECHO   = 4'd3,
      ST_MEDIDA        = 4'd4,
      ST_ARMAZENA      = 4'd5,
      ST_TRANSMITE     = 4'd6,
      ST_ESPERA_TX     = 4'd7,
      ST_PROXIMO       = 4'd8,
      ST_FINAL         = 4'd15
   } estado_t;

   // Even parity over a 7-bit character: parity bit makes the total count of ones even
   function automatic logic parity_even(input logic [6:0] data);
      return ^data;
   endfunction

   // Three-digit BCD increment that sticks at 999 instead of wrapping
   function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v == 12'h999) begin
         r = v;
      end else if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd9) begin
            r[7:4] = v[7:4] + 4'd1;
         end else begin
            r[7:4]  = 4'd0;
            r[11:8] = v[11:8] + 4'd1;
         end
      end
      return r;
   endfunction

   estado_t           state_r;
   logic              mensurar_d_r;
   logic              mensurar_rise_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [11:0]       cm_r;
   logic [11:0]       medida_r;
   logic [1:0]        idx_r;
   logic              trigger_r;
   logic              pronto_r;
   logic [6:0]        char_s;
   logic              start_s;

   logic              tx_r;
   logic              busy_r;
   logic              done_r;
   logic [10:0]       frame_r;
   logic [3:0]        bit_r;
   logic [BAUD_W-1:0] baud_r;

   assign mensurar_rise_s = mensurar & ~mensurar_d_r;
   assign start_s         = (state_r == ST_TRANSMITE);

   // Intra-centimetre count, wrapping modulo CM_CYCLES
   always_comb begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
      if (cnt_r == CNT_W'(CM_CYCLES - 1)) begin
         cnt_nxt_s = '0;
      end else begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end
   end

   // Character to send for the current index: three ASCII digits and then '#'
   always_comb begin
      char_s = 7'h23;
      case (idx_r)
         2'd0:    char_s = {3'b011, medida_r[11:8]};
         2'd1:    char_s = {3'b011, medida_r[7:4]};
         2'd2:    char_s = {3'b011, medida_r[3:0]};
         2'd3:    char_s = 7'h23;
         default: char_s = 7'h23;
      endcase
   end

   // Registered copy of mensurar for rising-edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mensurar_d_r <= 1'b0;
      end else begin
         mensurar_d_r <= mensurar;
      end
   end

   // Control FSM with the measurement datapath and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= ST_INICIAL;
         cnt_r     <= '0;
         cm_r      <= 12'h000;
         medida_r  <= 12'h000;
         idx_r     <= 2'd0;
         trigger_r <= 1'b0;
         pronto_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_INICIAL: begin
               if (mensurar_rise_s) begin
                  state_r <= ST_PREPARACAO;
               end
            end
            ST_PREPARACAO: begin
               cnt_r     <= '0;
               cm_r      <= 12'h000;
               idx_r     <= 2'd0;
               trigger_r <= 1'b1;   // rises together with entry to envia_trigger
               state_r   <= ST_ENVIA_TRIGGER;
            end
            ST_ENVIA_TRIGGER: begin
               if (cnt_r == CNT_W'(TRIGGER_CYCLES - 1)) begin
                  trigger_r <= 1'b0;
                  cnt_r     <= '0;
                  state_r   <= ST_ESPERA_ECHO;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_ESPERA_ECHO: begin
               // The first echo-high clock already counts toward the distance
               if (echo) begin
                  cnt_r   <= cnt_nxt_s;
                  state_r <= ST_MEDIDA;
                  if (cnt_nxt_s == CNT_W'(CM_HALF)) begin
                     cm_r <= bcd_inc_sat(cm_r);
                  end
               end
            end
            ST_MEDIDA: begin
               // Incrementing at mid-centimetre rounds to nearest
               if (echo) begin
                  cnt_r <= cnt_nxt_s;
                  if (cnt_nxt_s == CNT_W'(CM_HALF)) begin
                     cm_r <= bcd_inc_sat(cm_r);
                  end
               end else begin
                  state_r <= ST_ARMAZENA;
               end
            end
            ST_ARMAZENA: begin
               medida_r <= cm_r;
               state_r  <= ST_TRANSMITE;
            end
            ST_TRANSMITE: begin
               state_r <= ST_ESPERA_TX;
            end
            ST_ESPERA_TX: begin
               if (done_r) begin
                  state_r <= ST_PROXIMO;
               end
            end
            ST_PROXIMO: begin
               if (idx_r == 2'd3) begin
                  pronto_r <= 1'b1;
                  state_r  <= ST_FINAL;
               end else begin
                  idx_r   <= idx_r + 2'd1;
                  state_r <= ST_TRANSMITE;
               end
            end
            ST_FINAL: begin
               if (mensurar_rise_s) begin
                  pronto_r <= 1'b0;
                  state_r  <= ST_PREPARACAO;
               end
            end
            default: begin
               trigger_r <= 1'b0;
               pronto_r  <= 1'b0;
               state_r   <= ST_INICIAL;
            end
         endcase
      end
   end

   // UART transmitter: start, 7 data LSB first, even parity, 2 stop bits
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         frame_r <= 11'h7FF;
         bit_r   <= 4'd0;
         baud_r  <= '0;
      end else begin
         done_r <= 1'b0;
         if (!busy_r) begin
            if (start_s) begin
               frame_r <= {2'b11, parity_even(char_s), char_s, 1'b0};
               tx_r    <= 1'b0;
               busy_r  <= 1'b1;
               bit_r   <= 4'd0;
               baud_r  <= '0;
            end
         end else if (baud_r == BAUD_W'(BAUD_CYCLES - 1)) begin
            baud_r <= '0;
            if (bit_r == 4'd10) begin
               // end of the second stop bit
               busy_r <= 1'b0;
               done_r <= 1'b1;
               tx_r   <= 1'b1;
            end else begin
               bit_r   <= bit_r + 4'd1;
               frame_r <= {1'b1, frame_r[10:1]};
               tx_r    <= frame_r[1];
            end
         end else begin
            baud_r <= baud_r + BAUD_W'(1);
         end
      end
   end

   assign trigger      = trigger_r;
   assign pronto       = pronto_r;
   assign db_estado    = state_r;
   assign saida_serial = tx_r;
   assign medida2      = medida_r[11:8];
   assign medida1      = medida_r[7:4];
   assign medida0      = medida_r[3:0];

endmodule

// File: tb/tb_exp4_trena.sv
// ----------------------------------------------------------------------------
// tb_exp4_trena : self-checking bench for exp4_trena
//
// Runs with reduced timing parameters so that saturation and several
// randomized distances fit in a short run. Expected distances come from the
// closed-form rounding rule. Expected UART frames are built from the ASCII
// characters. The serial line is decoded by sampling each bit at mid-bit.
// ----------------------------------------------------------------------------
module tb_exp4_trena;

   localparam int TRIG = 20;
   localparam int CMC  = 11;
   localparam int CMH  = 5;
   localparam int BAUD = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       mensurar;
   logic       echo;
   logic       trigger;
   logic       saida_serial;
   logic [3:0] medida0;
   logic [3:0] medida1;
   logic [3:0] medida2;
   logic       pronto;
   logic [3:0] db_estado;

   int          n_vec = 0;
   int          n_err = 0;
   logic [11:0] prev_bcd = 12'h000;

   always #10 clock = ~clock;

   exp4_trena #(
      .TRIGGER_CYCLES(TRIG),
      .CM_CYCLES(CMC),
      .CM_HALF(CMH),
      .BAUD_CYCLES(BAUD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .mensurar(mensurar),
      .echo(echo),
      .trigger(trigger),
      .saida_serial(saida_serial),
      .medida0(medida0),
      .medida1(medida1),
      .medida2(medida2),
      .pronto(pronto),
      .db_estado(db_estado)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // distance in cm from echo-high clock count, rounded to nearest, clamped at 999
   function automatic int ref_cm(input int n);
      int c;
      if (n < CMH) c = 0;
      else         c = (n - CMH) / CMC + 1;
      if (c > 999) c = 999;
      return c;
   endfunction

   function automatic logic [10:0] ref_frame(input logic [6:0] ch);
      return {2'b11, ^ch, ch, 1'b0};
   endfunction

   // Decode one frame into its 11 sampled bits, starting from the start-bit edge
   task automatic rx_frame(output logic [10:0] fr);
      int w;
      w  = 0;
      fr = 11'h7FF;
      while (saida_serial !== 1'b0 && w < 12 * BAUD) begin
         @(negedge clock);
         w++;
      end
      if (saida_serial !== 1'b0) begin
         check("rx_start_timeout", 32'd0, 32'd1);
         return;
      end
      repeat (BAUD / 2) @(negedge clock);
      fr[0] = saida_serial;
      for (int i = 1; i < 11; i++) begin
         repeat (BAUD) @(negedge clock);
         fr[i] = saida_serial;
      end
   endtask

   // One full measurement with n echo-high clocks. poke raises mensurar during the echo.
   task automatic measure(input int n, input bit poke);
      int          lat;
      int          hi;
      int          w;
      int          c;
      logic [11:0] bcd;
      logic [10:0] fr;
      logic [6:0]  ch;
      c   = ref_cm(n);
      bcd = {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};

      @(negedge clock);
      mensurar = 1'b1;
      lat = 0;
      while (trigger !== 1'b1 && lat < 6) begin
         @(negedge clock);
         lat++;
      end
      check("trig_latency", 32'(lat <= 2), 32'd1);
      hi = 0;
      while (trigger === 1'b1 && hi < TRIG + 10) begin
         hi++;
         if (lat + hi >= 6) mensurar = 1'b0;
         @(negedge clock);
      end
      mensurar = 1'b0;
      check("trig_width", 32'(hi), 32'(TRIG));
      check("medida_hold", 32'({medida2, medida1, medida0}), 32'(prev_bcd));
      check("state_espera_echo", 32'(db_estado), 32'd3);

      repeat ($urandom_range(0, 15)) @(negedge clock);
      echo = 1'b1;
      for (int k = 0; k < n; k++) begin
         if (poke && k == n / 2)     mensurar = 1'b1;
         if (poke && k == n / 2 + 3) mensurar = 1'b0;
         @(negedge clock);
      end
      echo     = 1'b0;
      mensurar = 1'b0;

      for (int j = 0; j < 4; j++) begin
         case (j)
            0:       ch = 7'h30 + {3'b000, bcd[11:8]};
            1:       ch = 7'h30 + {3'b000, bcd[7:4]};
            2:       ch = 7'h30 + {3'b000, bcd[3:0]};
            default: ch = 7'h23;
         endcase
         rx_frame(fr);
         check("uart_frame", 32'(fr), 32'(ref_frame(ch)));
      end

      w = 0;
      while (pronto !== 1'b1 && w < 100) begin
         @(negedge clock);
         w++;
      end
      check("pronto", 32'(pronto), 32'd1);
      check("state_final", 32'(db_estado), 32'd15);
      check("medida", 32'({medida2, medida1, medida0}), 32'(bcd));
      prev_bcd = bcd;
   endtask

   initial begin
      int w;
      reset    = 1'b1;
      mensurar = 1'b0;
      echo     = 1'b0;
      repeat (5) @(negedge clock);
      check("rst_trigger", 32'(trigger), 32'd0);
      check("rst_serial", 32'(saida_serial), 32'd1);
      check("rst_pronto", 32'(pronto), 32'd0);
      check("rst_estado", 32'(db_estado), 32'd0);
      check("rst_medida", 32'({medida2, medida1, medida0}), 32'd0);
      reset = 1'b0;

      // echo while idle must not start anything
      @(negedge clock);
      echo = 1'b1;
      repeat (5) @(negedge clock);
      echo = 1'b0;
      @(negedge clock);
      check("idle_echo_ignored", 32'(db_estado), 32'd0);

      // rounding boundaries around the half-centimetre
      measure(CMH - 1, 1'b0);
      measure(CMH, 1'b0);
      measure(CMH + CMC - 1, 1'b0);
      measure(CMH + CMC, 1'b0);
      // 100 cm exactly at the half point, and truncation just below the next step
      measure(CMH + 99 * CMC, 1'b0);
      measure(CMH + 100 * CMC - 1, 1'b0);

      for (int i = 0; i < 10; i++) begin
         measure($urandom_range(1, 1200), (i % 3) == 1);
      end

      // saturation well above 999 cm
      measure(11500, 1'b0);

      // reset during the first frame of a transmission
      @(negedge clock);
      mensurar = 1'b1;
      repeat (5) @(negedge clock);
      mensurar = 1'b0;
      w = 0;
      while (db_estado !== 4'd3 && w < 100) begin
         @(negedge clock);
         w++;
      end
      check("rt_reach_espera_echo", 32'(db_estado), 32'd3);
      echo = 1'b1;
      repeat (40) @(negedge clock);
      echo = 1'b0;
      w = 0;
      while (saida_serial !== 1'b0 && w < 100) begin
         @(negedge clock);
         w++;
      end
      check("rt_frame_started", 32'(saida_serial), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1;
      check("rt_serial_high", 32'(saida_serial), 32'd1);
      check("rt_estado", 32'(db_estado), 32'd0);
      check("rt_pronto", 32'(pronto), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      check("rt_medida_cleared", 32'({medida2, medida1, medida0}), 32'd0);
      prev_bcd = 12'h000;

      // recovery after the abort
      measure(37, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
